seven_seg_mux: RTL and testbench

//   Parametrised N-digit multiplexed seven-segment driver; successor to the fixed 3-digit hex display.
//   - Captures a DATA_W-bit value on a load strobe.
//   - Renders the value as hex, or as decimal via a sequential double-dabble converter.
//   - Scans the digits at a fixed refresh rate.
//   - In the snake top level it sits between the UART-RX data/strobe (or the score counter) and the board seg/ca pins.

---
 rtl/seven_seg_mux.sv | 208 ++++++++++++++++++++
 tb/tb_seven_seg_mux.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_mux.sv
// seven_seg_mux: N-digit multiplexed seven-segment driver (hex or sequential double-dabble decimal).
// Latency: hex commit 1 cycle after load, decimal DATA_W+1 cycles; scan outputs registered, 1 cycle after index.
// Backpressure: busy is high while a value is being converted; loads seen while busy are dropped, not queued.
//
// Ports:
//   clk   system clock               rst   asynchronous reset, active-high
//   value value to display           load  single-cycle load strobe (accepted when busy==0)
//   mode  0 = hex, 1 = decimal       busy  conversion in progress
//   ovf   last committed value did not fit in DIGITS digits
//   seg   segments {g,f,e,d,c,b,a}, active-low
//   ca    one-hot digit enable, active-high, bit 0 = least significant digit
// Optional build macro: LEADING_ZERO_BLANK_EN blanks zero digits above the most significant non-zero digit.

module seven_seg_mux #(
   parameter int CLK_HZ     = 25_000_000,
   parameter int REFRESH_HZ = 1000,
   parameter int DIGITS     = 3,
   parameter int DATA_W     = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] value,
   input  logic              load,
   input  logic              mode,
   output logic              busy,
   output logic              ovf,
   output logic [6:0]        seg,
   output logic [DIGITS-1:0] ca
);

   localparam int DIV_RAW = CLK_HZ / (REFRESH_HZ * DIGITS);
   localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   // One spare nibble above the displayed digits catches decimal overflow.
   localparam int BCD_W   = 4 * DIGITS + 4;
   localparam int CNT_W   = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CONV   = 2'd1,
      COMMIT = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic                  accept, conv_step, commit;

   logic [DATA_W-1:0]     shreg_q;
   logic [BCD_W-1:0]      bcd_q, bcd_adj;
   logic [CNT_W-1:0]      cnt_q;
   logic                  mode_q;
   logic                  sticky_q;
   logic [4*DIGITS-1:0]   disp_q;
   logic                  ovf_q;

   logic [63:0]           hex_wide;
   logic                  hex_ovf, dec_ovf, commit_ovf;
   logic [4*DIGITS-1:0]   commit_dig;

   logic [DIV_W-1:0]      div_q;
   logic [IDX_W-1:0]      idx_q;
   logic                  tc;
   logic [DIGITS-1:0]     ca_q;
   logic [6:0]            seg_q;
   logic [3:0]            cur_nib;
   logic [6:0]            cur_seg;
   logic [DIGITS-1:0]     blank_mask;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (load) state_d = mode ? CONV : COMMIT;
         CONV:    if (cnt_q == CNT_W'(DATA_W - 1)) state_d = COMMIT;
         COMMIT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      busy      = (state_q != IDLE);
      accept    = (state_q == IDLE) && load;
      conv_step = (state_q == CONV);
      commit    = (state_q == COMMIT);
   end

   // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < DIGITS + 1; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
   end

   // In hex mode shreg_q still holds the raw latched value at commit time.
   always_comb begin
      hex_wide   = 64'(shreg_q);
      hex_ovf    = ((hex_wide >> (4 * DIGITS)) != 64'd0);
      // A one leaving the top of the BCD register means the value had more digits than we keep.
      dec_ovf    = sticky_q || (bcd_q[BCD_W-1 -: 4] != 4'd0);
      commit_ovf = mode_q ? dec_ovf : hex_ovf;
      commit_dig = mode_q ? bcd_q[4*DIGITS-1:0] : hex_wide[4*DIGITS-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg_q  <= '0;
         bcd_q    <= '0;
         cnt_q    <= '0;
         mode_q   <= 1'b0;
         sticky_q <= 1'b0;
         disp_q   <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (accept) begin
            shreg_q  <= value;
            mode_q   <= mode;
            bcd_q    <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
         end else if (conv_step) begin
            {bcd_q, shreg_q} <= {bcd_adj[BCD_W-2:0], shreg_q, 1'b0};
            sticky_q         <= sticky_q | bcd_adj[BCD_W-1];
            cnt_q            <= cnt_q + CNT_W'(1);
         end
         if (commit) begin
            disp_q <= commit_dig;
            ovf_q  <= commit_ovf;
         end
      end
   end

   assign ovf = ovf_q;

   // ---------------- Scan ----------------
`ifdef LEADING_ZERO_BLANK_EN
   logic upper_zero;
   always_comb begin
      blank_mask = '0;
      upper_zero = 1'b1;
      // Walk down from the top digit; digit 0 is never blanked.
      for (int i = DIGITS - 1; i >= 1; i--) begin
         upper_zero    = upper_zero && (disp_q[4*i +: 4] == 4'd0);
         blank_mask[i] = upper_zero;
      end
   end
`else
   assign blank_mask = '0;
`endif

   function automatic logic [6:0] glyph(input logic [3:0] nib);
      case (nib)
         4'h0: glyph = 7'h40;
         4'h1: glyph = 7'h79;
         4'h2: glyph = 7'h24;
         4'h3: glyph = 7'h30;
         4'h4: glyph = 7'h19;
         4'h5: glyph = 7'h12;
         4'h6: glyph = 7'h02;
         4'h7: glyph = 7'h78;
         4'h8: glyph = 7'h00;
         4'h9: glyph = 7'h10;
         4'hA: glyph = 7'h08;
         4'hB: glyph = 7'h03;
         4'hC: glyph = 7'h46;
         4'hD: glyph = 7'h21;
         4'hE: glyph = 7'h06;
         default: glyph = 7'h0E;
      endcase
   endfunction

   always_comb begin
      cur_nib = disp_q[{idx_q, 2'b00} +: 4];
      if (ovf_q)                 cur_seg = 7'h3F;
      else if (blank_mask[idx_q]) cur_seg = 7'h7F;
      else                       cur_seg = glyph(cur_nib);
   end

   assign tc = (div_q == DIV_W'(DIV - 1));

   // ca/seg are loaded only at terminal count, so they show the index held before it advances.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q <= '0;
         idx_q <= '0;
         ca_q  <= '0;
         seg_q <= 7'h7F;
      end else begin
         div_q <= tc ? '0 : div_q + DIV_W'(1);
         if (tc) begin
            ca_q  <= DIGITS'(1) << idx_q;
            seg_q <= cur_seg;
            idx_q <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
         end
      end
   end

   assign ca  = ca_q;
   assign seg = seg_q;

endmodule

// File: tb/tb_seven_seg_mux.sv
// Bench for seven_seg_mux: two instances (3 digits / divider 1, 2 digits / divider 4),
// randomized loads checked against an arithmetic model of the displayed digits.
`timescale 1ns/1ps
module tb_seven_seg_mux;

   localparam int W    = 8;
   localparam int D1   = 3;
   localparam int DIV1 = 1;
   localparam int D2   = 2;
   localparam int DIV2 = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [W-1:0] value1, value2;
   logic load1, load2, mode1, mode2;
   logic busy1, busy2, ovf1, ovf2;
   logic [6:0] seg1, seg2;
   logic [D1-1:0] ca1;
   logic [D2-1:0] ca2;

   int n_checks = 0;
   int n_fail   = 0;

   logic [6:0] cap_seg [8];
   bit         cap_seen[8];
   int         cap_bad;

   seven_seg_mux #(.CLK_HZ(3000), .REFRESH_HZ(1000), .DIGITS(D1), .DATA_W(W)) u_dut1 (
      .clk(clk), .rst(rst), .value(value1), .load(load1), .mode(mode1),
      .busy(busy1), .ovf(ovf1), .seg(seg1), .ca(ca1));

   seven_seg_mux #(.CLK_HZ(8000), .REFRESH_HZ(1000), .DIGITS(D2), .DATA_W(W)) u_dut2 (
      .clk(clk), .rst(rst), .value(value2), .load(load2), .mode(mode2),
      .busy(busy2), .ovf(ovf2), .seg(seg2), .ca(ca2));

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic logic [6:0] glyph(input int d);
      case (d)
         0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
         4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
         8: return 7'h00;  9: return 7'h10; 10: return 7'h08; 11: return 7'h03;
        12: return 7'h46; 13: return 7'h21; 14: return 7'h06; default: return 7'h0E;
      endcase
   endfunction

   function automatic bit exp_ovf(input longint v, input bit m, input int nd);
      longint base = m ? 10 : 16;
      longint lim  = 1;
      for (int i = 0; i < nd; i++) lim = lim * base;
      return v >= lim;
   endfunction

   function automatic logic [6:0] exp_seg(input longint v, input bit m, input int nd, input int i);
      longint base = m ? 10 : 16;
      longint p    = 1;
      for (int j = 0; j < i; j++) p = p * base;
      if (exp_ovf(v, m, nd)) return 7'h3F;
`ifdef LEADING_ZERO_BLANK_EN
      if (i > 0 && v < p) return 7'h7F;
`endif
      return glyph(int'((v / p) % base));
   endfunction

   // ---------------- stimulus / observation helpers ----------------
   task automatic do_load(input int which, input int v, input bit m);
      if (which == 1) begin value1 = W'(v); mode1 = m; load1 = 1'b1; end
      else            begin value2 = W'(v); mode2 = m; load2 = 1'b1; end
      @(negedge clk);
      load1 = 1'b0;
      load2 = 1'b0;
   endtask

   // Waits one full scan so every digit is refreshed, then records one more full scan.
   task automatic scan_capture(input int which);
      int nd, dv;
      logic [7:0] ca_v;
      logic [6:0] s;
      nd = (which == 1) ? D1 : D2;
      dv = (which == 1) ? DIV1 : DIV2;
      for (int i = 0; i < 8; i++) begin cap_seen[i] = 1'b0; cap_seg[i] = 7'h7F; end
      cap_bad = 0;
      repeat (nd * dv) @(negedge clk);
      for (int c = 0; c < nd * dv; c++) begin
         ca_v = (which == 1) ? 8'(ca1) : 8'(ca2);
         s    = (which == 1) ? seg1 : seg2;
         if ($onehot(ca_v)) begin
            for (int k = 0; k < 8; k++)
               if (ca_v[k]) begin cap_seen[k] = 1'b1; cap_seg[k] = s; end
         end else begin
            cap_bad++;
         end
         @(negedge clk);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      load1 = 0; load2 = 0; mode1 = 0; mode2 = 0; value1 = '0; value2 = '0;
      #1 rst = 1'b1;
      #1;
      n_checks++;
      if ({busy1, ovf1, seg1, ca1} !== {1'b0, 1'b0, 7'h7F, 3'b000}) begin
         n_fail++;
         $display("FAIL reset_dut1: busy=%b ovf=%b seg=%h ca=%b required 0 0 7f 000", busy1, ovf1, seg1, ca1);
      end
      n_checks++;
      if ({busy2, ovf2, seg2, ca2} !== {1'b0, 1'b0, 7'h7F, 2'b00}) begin
         n_fail++;
         $display("FAIL reset_dut2: busy=%b ovf=%b seg=%h ca=%b required 0 0 7f 00", busy2, ovf2, seg2, ca2);
      end
      @(negedge clk);
      rst = 1'b0;
      // DIV=1: scan starts on the very first edge and advances every cycle.
      for (int e = 1; e <= 4; e++) begin
         @(negedge clk);
         n_checks++;
         if (ca1 !== 3'(1 << ((e - 1) % D1)) || seg1 !== exp_seg(0, 0, D1, (e - 1) % D1)) begin
            n_fail++;
            $display("FAIL scan_start_dut1 edge %0d: ca=%b seg=%h required ca=%b seg=%h",
                     e, ca1, seg1, 3'(1 << ((e - 1) % D1)), exp_seg(0, 0, D1, (e - 1) % D1));
         end
         if (e == 3 || e == 4) begin
            n_checks++;
            if (ca2 !== ((e == 4) ? 2'b01 : 2'b00)) begin
               n_fail++;
               $display("FAIL scan_start_dut2 edge %0d: ca=%b required %b", e, ca2, (e == 4) ? 2'b01 : 2'b00);
            end
         end
      end
   endtask

   task automatic test_hex();
      int v;
      for (int t = 0; t < 6; t++) begin
         v = (t == 0) ? 'hA5 : int'($urandom_range(0, 255));
         do_load(1, v, 1'b0);
         n_checks++;
         if (busy1 !== 1'b1) begin n_fail++; $display("FAIL hex_busy_high v=%0h: busy=%b required 1", v, busy1); end
         @(negedge clk);
         n_checks++;
         if (busy1 !== 1'b0 || ovf1 !== 1'b0) begin
            n_fail++; $display("FAIL hex_busy_low v=%0h: busy=%b ovf=%b required 0 0", v, busy1, ovf1);
         end
         scan_capture(1);
         n_checks++;
         if (cap_bad !== 0) begin n_fail++; $display("FAIL hex_onehot v=%0h: bad=%0d required 0", v, cap_bad); end
         for (int i = 0; i < D1; i++) begin
            n_checks++;
            if (!cap_seen[i] || cap_seg[i] !== exp_seg(v, 0, D1, i)) begin
               n_fail++;
               $display("FAIL hex_digit v=%0h d%0d: seen=%0d seg=%h required %h", v, i, cap_seen[i], cap_seg[i], exp_seg(v, 0, D1, i));
            end
         end
      end
   endtask

   task automatic test_decimal();
      int v, hi;
      for (int t = 0; t < 5; t++) begin
         v = (t == 0) ? 237 : int'($urandom_range(0, 255));
         do_load(1, v, 1'b1);
         hi = 0;
         for (int j = 0; j <= W; j++) begin
            if (busy1 === 1'b1) hi++;
            @(negedge clk);
         end
         n_checks++;
         if (hi != W + 1 || busy1 !== 1'b0) begin
            n_fail++; $display("FAIL dec_busy v=%0d: busy_cycles=%0d busy_now=%b required %0d 0", v, hi, busy1, W + 1);
         end
         n_checks++;
         if (ovf1 !== 1'b0) begin n_fail++; $display("FAIL dec_ovf v=%0d: ovf=%b required 0", v, ovf1); end
         scan_capture(1);
         for (int i = 0; i < D1; i++) begin
            n_checks++;
            if (!cap_seen[i] || cap_seg[i] !== exp_seg(v, 1, D1, i)) begin
               n_fail++;
               $display("FAIL dec_digit v=%0d d%0d: seen=%0d seg=%h required %h", v, i, cap_seen[i], cap_seg[i], exp_seg(v, 1, D1, i));
            end
         end
      end
   endtask

   task automatic test_busy_ignore();
      int hi;
      do_load(1, 237, 1'b1);
      hi = 0;
      for (int c = 0; c < 20; c++) begin
         if (c == 2) begin value1 = 8'd5; mode1 = 1'b0; load1 = 1'b1; end
         if (c == 3) load1 = 1'b0;
         if (busy1 === 1'b1) hi++;
         @(negedge clk);
      end
      n_checks++;
      if (hi != W + 1) begin n_fail++; $display("FAIL ignore_busy_cycles: got %0d required %0d", hi, W + 1); end
      scan_capture(1);
      for (int i = 0; i < D1; i++) begin
         n_checks++;
         if (!cap_seen[i] || cap_seg[i] !== exp_seg(237, 1, D1, i)) begin
            n_fail++;
            $display("FAIL ignore_digit d%0d: seg=%h required %h", i, cap_seg[i], exp_seg(237, 1, D1, i));
         end
      end
   endtask

   task automatic test_overflow();
      int v;
      bit m, prev_ovf, e_ovf;
      prev_ovf = 1'b0;
      for (int t = 0; t < 8; t++) begin
         if (t == 0)      begin v = 100; m = 1'b1; end
         else if (t == 1) begin v = 99;  m = 1'b1; end
         else begin v = int'($urandom_range(0, 255)); m = 1'($urandom_range(0, 1)); end
         e_ovf = exp_ovf(v, m, D2);
         do_load(2, v, m);
         n_checks++;
         if (ovf2 !== prev_ovf) begin n_fail++; $display("FAIL ovf_early v=%0d: ovf=%b required %b", v, ovf2, prev_ovf); end
         repeat (m ? W + 1 : 1) @(negedge clk);
         n_checks++;
         if (busy2 !== 1'b0 || ovf2 !== e_ovf) begin
            n_fail++; $display("FAIL ovf_commit v=%0d m=%0d: busy=%b ovf=%b required 0 %b", v, m, busy2, ovf2, e_ovf);
         end
         scan_capture(2);
         n_checks++;
         if (cap_bad !== 0) begin n_fail++; $display("FAIL ovf_onehot v=%0d: bad=%0d required 0", v, cap_bad); end
         for (int i = 0; i < D2; i++) begin
            n_checks++;
            if (!cap_seen[i] || cap_seg[i] !== exp_seg(v, m, D2, i)) begin
               n_fail++;
               $display("FAIL ovf_digit v=%0d m=%0d d%0d: seg=%h required %h", v, m, i, cap_seg[i], exp_seg(v, m, D2, i));
            end
         end
         prev_ovf = e_ovf;
      end
   endtask

   task automatic test_reset_midconv();
      do_load(2, 250, 1'b1);
      repeat (W + 1) @(negedge clk);
      n_checks++;
      if (ovf2 !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_ovf: ovf=%b required 1", ovf2); end
      do_load(1, 200, 1'b1);
      repeat (3) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      n_checks++;
      if ({busy1, ovf1, seg1, ca1} !== {1'b0, 1'b0, 7'h7F, 3'b000}) begin
         n_fail++;
         $display("FAIL midrst_dut1: busy=%b ovf=%b seg=%h ca=%b required 0 0 7f 000", busy1, ovf1, seg1, ca1);
      end
      n_checks++;
      if ({busy2, ovf2, seg2, ca2} !== {1'b0, 1'b0, 7'h7F, 2'b00}) begin
         n_fail++;
         $display("FAIL midrst_dut2: busy=%b ovf=%b seg=%h ca=%b required 0 0 7f 00", busy2, ovf2, seg2, ca2);
      end
      @(negedge clk);
      rst = 1'b0;
      scan_capture(1);
      n_checks++;
      if (busy1 !== 1'b0 || ovf1 !== 1'b0) begin
         n_fail++; $display("FAIL midrst_idle: busy=%b ovf=%b required 0 0", busy1, ovf1);
      end
      for (int i = 0; i < D1; i++) begin
         n_checks++;
         if (!cap_seen[i] || cap_seg[i] !== exp_seg(0, 1, D1, i)) begin
            n_fail++;
            $display("FAIL midrst_digit d%0d: seg=%h required %h", i, cap_seg[i], exp_seg(0, 1, D1, i));
         end
      end
   endtask

   initial begin
      test_reset();
      test_hex();
      test_decimal();
      test_busy_ignore();
      test_overflow();
      test_reset_midconv();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
